write_queue: RTL and testbench

WRITE_QUEUE -- requirements
Module: write_queue

---
 rtl/write_queue_pkg.sv | 13 +
 rtl/wq_lookup.sv | 35 +++
 rtl/write_queue.sv | 90 +++++++++
 tb/tb_write_queue.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/write_queue_pkg.sv
// Shared CPU register-file definitions: default register widths and the
// packed write-request layout used by the write queue and its users.
package write_queue_pkg;

  localparam int REG_BITS      = 4;
  localparam int REG_ADDR_BITS = 3;

  typedef struct packed {
    logic [REG_ADDR_BITS-1:0] addr;
    logic [REG_BITS-1:0]      data;
  } wr_req_t;

endpackage

// File: rtl/wq_lookup.sv
// Forwarding search over the queued writes: reports whether any occupied
// entry targets the queried register and returns the youngest such value.
module wq_lookup #(
  parameter int bits      = 4,
  parameter int addr_bits = 3,
  parameter int depth     = 4
) (
  input  logic [depth-1:0][addr_bits-1:0] i_mem_addr,
  input  logic [depth-1:0][bits-1:0]      i_mem_data,
  input  logic [$clog2(depth)-1:0]        i_head,
  input  logic [$clog2(depth):0]          i_count,
  input  logic [addr_bits-1:0]            i_lookup_addr,
  output logic                            o_hit,
  output logic [bits-1:0]                 o_data
);

  localparam int PW = $clog2(depth);

  logic [PW-1:0] w_slot;

  // Walk from head (oldest) towards tail so a later match overrides an older one.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_slot = i_head;
    for (int k = 0; k < depth; k++) begin
      w_slot = i_head + PW'(k);
      if (((PW+1)'(k) < i_count) && (i_mem_addr[w_slot] == i_lookup_addr)) begin
        o_hit  = 1'b1;
        o_data = i_mem_data[w_slot];
      end
    end
  end

endmodule

// File: rtl/write_queue.sv
// In-order register write queue with a combinational forwarding lookup.
// Handshake: a write is taken on a rising edge where in_valid && in_ready;
// in_ready = !full and never depends on in_valid. Downstream has no ready:
// the head is written (and popped) on every edge where out_wenable is high.
module write_queue
  import write_queue_pkg::*;
#(
  parameter int bits      = REG_BITS,
  parameter int addr_bits = REG_ADDR_BITS,
  parameter int depth     = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [addr_bits-1:0]     in_addr,
  input  logic [bits-1:0]          in_data,
  input  logic                     out_stall,
  output logic                     out_wenable,
  output logic [addr_bits-1:0]     out_waddr,
  output logic [bits-1:0]          out_wdata,
  input  logic [addr_bits-1:0]     lookup_addr,
  output logic                     lookup_hit,
  output logic [bits-1:0]          lookup_data,
  output logic [$clog2(depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(depth);

  logic [depth-1:0][addr_bits-1:0] r_mem_addr;
  logic [depth-1:0][bits-1:0]      r_mem_data;
  logic [PW-1:0]                   r_head;
  logic [PW-1:0]                   r_tail;
  logic [PW:0]                     r_count;
  logic                            w_push;
  logic                            w_pop;

  assign full        = (r_count == (PW+1)'(depth));
  assign empty       = (r_count == '0);
  assign in_ready    = !full;
  assign out_wenable = !empty && !out_stall;
  assign out_waddr   = empty ? '0 : r_mem_addr[r_head];
  assign out_wdata   = empty ? '0 : r_mem_data[r_head];
  assign count       = r_count;

  // A refused push (full) stays refused even if the head drains this edge.
  assign w_push = in_valid && in_ready && rstn;
  assign w_pop  = out_wenable;

  // Storage carries no reset; occupancy is defined solely by head/count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_tail] <= in_addr;
      r_mem_data[r_tail] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  wq_lookup #(
    .bits      (bits),
    .addr_bits (addr_bits),
    .depth     (depth)
  ) u_lookup (
    .i_mem_addr    (r_mem_addr),
    .i_mem_data    (r_mem_data),
    .i_head        (r_head),
    .i_count       (r_count),
    .i_lookup_addr (lookup_addr),
    .o_hit         (lookup_hit),
    .o_data        (lookup_data)
  );

endmodule

// File: tb/tb_write_queue.sv
// Directed bench for write_queue: driver tasks push expected writes into a
// queue, a negedge monitor checks every drained write against it.
module tb_write_queue;
  import write_queue_pkg::*;

  localparam int W = REG_ADDR_BITS + REG_BITS;

  // clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic                     in_valid;
  logic                     in_ready;
  logic [REG_ADDR_BITS-1:0] in_addr;
  logic [REG_BITS-1:0]      in_data;
  logic                     out_stall;
  logic                     out_wenable;
  logic [REG_ADDR_BITS-1:0] out_waddr;
  logic [REG_BITS-1:0]      out_wdata;
  logic [REG_ADDR_BITS-1:0] lookup_addr;
  logic                     lookup_hit;
  logic [REG_BITS-1:0]      lookup_data;
  logic [2:0]               count;
  logic                     full;
  logic                     empty;

  write_queue dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .out_stall   (out_stall),
    .out_wenable (out_wenable),
    .out_waddr   (out_waddr),
    .out_wdata   (out_wdata),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  logic [W-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] a, input logic [3:0] d, input bit acc);
    wr_req_t req;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    req.addr = a;
    req.data = d;
    if (acc) exp_q.push_back(req);
    tick();
    in_valid = 1'b0;
  endtask

  // scoreboard monitor: each drained write must be the oldest expected one
  always @(negedge clk) begin
    if (rstn && out_wenable) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL drain_unexpected: got %0h expected none", {out_waddr, out_wdata});
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({out_waddr, out_wdata} === e) n_pass++;
        else $display("FAIL drain_order: got %0h expected %0h", {out_waddr, out_wdata}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rstn        = 1'b0;
    in_valid    = 1'b1;
    in_addr     = 3'd2;
    in_data     = 4'hA;
    out_stall   = 1'b0;
    lookup_addr = 3'd2;

    // reset with in_valid held high
    repeat (2) tick();
    check("rst_empty",   empty, 1);
    check("rst_full",    full, 0);
    check("rst_ready",   in_ready, 1);
    check("rst_wen",     out_wenable, 0);
    check("rst_count",   count, 0);
    check("rst_wdata",   out_wdata, 0);
    check("rst_hit",     lookup_hit, 0);
    check("rst_ldata",   lookup_data, 0);
    rstn     = 1'b1;
    in_valid = 1'b0;
    tick();

    // first push: visible one edge later, not combinationally
    in_valid = 1'b1;
    in_addr  = 3'd2;
    in_data  = 4'b1010;
    exp_q.push_back({3'd2, 4'b1010});
    #1;
    check("lat_no_comb", out_wenable, 0);
    tick();
    in_valid = 1'b0;
    check("first_wen",   out_wenable, 1);
    check("first_wdata", out_wdata, 4'b1010);
    check("first_waddr", out_waddr, 2);
    tick();
    check("first_empty", empty, 1);

    // fill while stalled, 5th push refused
    out_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push(3'(i), 4'(i), 1'b1);
    check("fill_count", count, 4);
    check("fill_full",  full, 1);
    check("fill_ready", in_ready, 0);
    check("fill_wen",   out_wenable, 0);
    push(3'd5, 4'd5, 1'b0);
    check("fill_refused", count, 4);
    out_stall = 1'b0;
    repeat (4) tick();
    check("fill_drained", empty, 1);
    check("fill_cnt0",    count, 0);

    // simultaneous push and pop
    out_stall = 1'b1;
    push(3'd1, 4'd1, 1'b1);
    push(3'd2, 4'd2, 1'b1);
    check("conc_cnt2", count, 2);
    out_stall = 1'b0;
    push(3'd3, 4'd3, 1'b1);
    check("conc_cnt_hold", count, 2);
    out_stall = 1'b1;
    push(3'd4, 4'd4, 1'b1);
    push(3'd5, 4'd5, 1'b1);
    check("conc_full", full, 1);
    out_stall = 1'b0;
    push(3'd6, 4'd6, 1'b0);
    check("conc_full_pushpop", count, 3);
    repeat (3) tick();
    check("conc_empty", empty, 1);

    // forwarding
    out_stall = 1'b1;
    push(3'd3, 4'b0001, 1'b1);
    push(3'd3, 4'b1111, 1'b1);
    push(3'd5, 4'd7, 1'b1);
    lookup_addr = 3'd3;
    #1;
    check("fwd_hit3",  lookup_hit, 1);
    check("fwd_data3", lookup_data, 4'b1111);
    lookup_addr = 3'd6;
    #1;
    check("fwd_hit6",  lookup_hit, 0);
    check("fwd_data6", lookup_data, 0);
    in_valid = 1'b1;
    in_addr  = 3'd6;
    in_data  = 4'd9;
    exp_q.push_back({3'd6, 4'd9});
    #1;
    check("fwd_push_excl", lookup_hit, 0);
    tick();
    in_valid = 1'b0;
    check("fwd_new_hit",  lookup_hit, 1);
    check("fwd_new_data", lookup_data, 9);
    lookup_addr = 3'd3;
    out_stall   = 1'b0;
    tick();
    check("fwd_head_pop_wen",  out_wenable, 1);
    check("fwd_head_pop_hit",  lookup_hit, 1);
    check("fwd_head_pop_data", lookup_data, 4'b1111);
    tick();
    check("fwd_gone_hit",  lookup_hit, 0);
    check("fwd_gone_data", lookup_data, 0);
    repeat (2) tick();
    check("fwd_empty", empty, 1);

    // wrap-around with back-to-back push/pop
    for (int i = 0; i < 10; i++) push(3'(i), 4'(i), 1'b1);
    tick();
    check("wrap_empty", empty, 1);

    // mid-operation reset discards pending entries
    out_stall = 1'b1;
    push(3'd1, 4'd1, 1'b1);
    push(3'd2, 4'd2, 1'b1);
    push(3'd3, 4'd3, 1'b1);
    check("mid_count3", count, 3);
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check("mid_empty", empty, 1);
    check("mid_count", count, 0);
    check("mid_wen",   out_wenable, 0);
    check("mid_wdata", out_wdata, 0);
    out_stall = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (2) tick();
    check("post_rst_empty", empty, 1);
    check("post_rst_wen",   out_wenable, 0);
    push(3'd7, 4'd5, 1'b1);
    check("post_rst_wdata", out_wdata, 5);
    tick();
    check("post_rst_drained", empty, 1);

    tick();
    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
